hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the performance counters.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 id_rs1, id_rs2  in  5 each  source register numbers of the instruction in ID.
REQ-005 id_rs1_used, id_rs2_used  in  1 each  the ID instruction actually reads rs1 / rs2.
REQ-006 ex_rd  in  5  destination register of the instruction in EX.
REQ-007 ex_mem_read  in  1  the EX instruction is a load.
REQ-008 ex_branch_taken  in  1  a branch or jump resolved taken in EX this cycle.
REQ-009 dmem_busy  in  1  data memory not ready; the MEM access must repeat.
REQ-010 wb_halt  in  1  an ecall/ebreak is retiring in WB.
REQ-011 pc_write  out  1  PC register load enable.
REQ-012 ifid_write  out  1  IF/ID register load enable.
REQ-013 ifid_flush  out  1  clear IF/ID to a NOP on this edge.
REQ-014 hazard_ctrl_mux  out  1  zero the EX/MEM/WB control fields entering ID/EX (bubble insertion).
REQ-015 pipe_en  out  1  load enable for ID/EX, EX/MEM and MEM/WB.
REQ-016 halted  out  1  the core is halted.
REQ-017 stall_cnt, flush_cnt, freeze_cnt  out  CNT_W each  saturating event counters.

Function
REQ-018 The block SHALL implement the FSM states RUN, FREEZE and HALT, with RUN as the reset state.
REQ-019 load_use SHALL equal ex_mem_read && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)).
REQ-020 In RUN, the outputs SHALL be prioritised as wb_halt > dmem_busy > ex_branch_taken > load_use > normal.
REQ-021 In RUN with wb_halt, the block SHALL drive pc_write=ifid_write=pipe_en=0 and enter HALT on the next edge.
REQ-022 In RUN with dmem_busy (no halt), the block SHALL drive pc_write=ifid_write=pipe_en=0, ifid_flush=0 and hazard_ctrl_mux=0, and enter FREEZE on the next edge.
REQ-023 In FREEZE, the block SHALL hold all enables at 0 while dmem_busy=1, and return to RUN on the first edge with dmem_busy=0. In the exit cycle the RUN rules SHALL apply combinationally, so a branch or load-use hazard held during the freeze is handled then.
REQ-024 In RUN with ex_branch_taken, the block SHALL drive pc_write=1, ifid_flush=1, hazard_ctrl_mux=1 and pipe_en=1. Latency is 0 cycles: the flush takes effect on the same edge that loads the target PC.
REQ-025 In RUN with load_use (no branch), the block SHALL drive pc_write=0, ifid_write=0, hazard_ctrl_mux=1 and pipe_en=1, giving exactly one bubble per load-use pair.
REQ-026 A load-use pair that coincides with a taken branch SHALL produce no stall, because the ID instruction is flushed.
REQ-027 In RUN with no hazard, the block SHALL drive pc_write=ifid_write=pipe_en=1 and ifid_flush=hazard_ctrl_mux=0.
REQ-028 In HALT, all enables SHALL be 0 and halted=1; only rst leaves HALT, and wb_halt is ignored while halted.
REQ-029 stall_cnt SHALL increment on each cycle of REQ-025, flush_cnt on each cycle of REQ-024, and freeze_cnt on each cycle of REQ-022 and of REQ-023 while dmem_busy=1.
REQ-030 The counters SHALL saturate at 2^CNT_W-1 and SHALL NOT increment in HALT.
REQ-031 The outputs SHALL be combinational from the state and inputs, and the state and counters SHALL be registered.

Reset
REQ-032 On rst=1 at an edge, the block SHALL set the state to RUN and all counters to 0. This applies mid-FREEZE and mid-HALT.
REQ-033 While rst=1, the outputs SHALL read pc_write=ifid_write=pipe_en=1, ifid_flush=hazard_ctrl_mux=halted=0.

Structure
REQ-034 The FSM state encoding (2-bit RUN=0, FREEZE=1, HALT=2) and the x0 register index constant SHALL live in the shared pipeline package.
REQ-035 The saturating counter SHALL be one sub-module, sat_counter (inputs clk, rst, inc; output count), instantiated three times.

Verification
REQ-036 Bench scenario: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 for one cycle -> pc_write=0, ifid_write=0, hazard_ctrl_mux=1, stall_cnt 0->1; next cycle with ex_mem_read=0 -> all enables 1.
REQ-037 Bench scenario: load-use with ex_rd=0, or with id_rs2=5 and id_rs2_used=0 -> no stall, stall_cnt unchanged.
REQ-038 Bench scenario: ex_branch_taken=1 together with load_use -> ifid_flush=1, hazard_ctrl_mux=1, pc_write=1, flush_cnt+1, stall_cnt+0.
REQ-039 Bench scenario: dmem_busy=1 for 3 cycles with ex_branch_taken=1 held -> pipe_en=0 for 3 cycles, freeze_cnt=3; on the exit cycle ifid_flush=1, flush_cnt=1.
REQ-040 Bench scenario: wb_halt=1 pulse -> halted=1 from the next cycle and stays 1 with wb_halt=0; rst=1 for one edge -> halted=0, counters 0.
REQ-041 Bench scenario: with CNT_W=4, hold load_use for 20 cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM encoding and architectural register constants.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_HALT   = 2'd2
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory freezes and halt,
// with saturating counters for each event type.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             dmem_busy,
  input  logic             wb_halt,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             hazard_ctrl_mux,
  output logic             pipe_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  state_e state_q;
  state_e state_d;
  logic   load_use;
  logic   run_mode;
  logic   stall_inc;
  logic   flush_inc;
  logic   freeze_inc;

  assign load_use = ex_mem_read && (ex_rd != REG_X0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  // The freeze exit cycle is evaluated with the full RUN priority chain.
  assign run_mode = (state_q != ST_HALT) && !((state_q != ST_RUN) && dmem_busy);

  always_comb begin
    pc_write        = 1'b1;
    ifid_write      = 1'b1;
    ifid_flush      = 1'b0;
    hazard_ctrl_mux = 1'b0;
    pipe_en         = 1'b1;
    state_d         = state_q;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    freeze_inc      = 1'b0;

    if (rst) begin
      state_d = ST_RUN;
    end else if (state_q == ST_HALT) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_en    = 1'b0;
    end else if (!run_mode) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_en    = 1'b0;
      freeze_inc = 1'b1;
      state_d    = ST_FREEZE;
    end else if (wb_halt) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_en    = 1'b0;
      state_d    = ST_HALT;
    end else if (dmem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_en    = 1'b0;
      freeze_inc = 1'b1;
      state_d    = ST_FREEZE;
    end else if (ex_branch_taken) begin
      // The flushed ID instruction makes any coincident load-use irrelevant.
      ifid_flush      = 1'b1;
      hazard_ctrl_mux = 1'b1;
      flush_inc       = 1'b1;
      state_d         = ST_RUN;
    end else if (load_use) begin
      pc_write        = 1'b0;
      ifid_write      = 1'b0;
      hazard_ctrl_mux = 1'b1;
      stall_inc       = 1'b1;
      state_d         = ST_RUN;
    end else begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign halted = (state_q == ST_HALT) && !rst;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (freeze_inc),
    .count (freeze_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a 4-bit counter build so saturation is reachable.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_rs1_used, id_rs2_used;
  logic             ex_mem_read, ex_branch_taken, dmem_busy, wb_halt;
  logic             pc_write, ifid_write, ifid_flush, hazard_ctrl_mux, pipe_en, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .dmem_busy       (dmem_busy),
    .wb_halt         (wb_halt),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .hazard_ctrl_mux (hazard_ctrl_mux),
    .pipe_en         (pipe_en),
    .halted          (halted),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .freeze_cnt      (freeze_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checks pc_write, ifid_write, ifid_flush, hazard_ctrl_mux, pipe_en, halted together.
  task automatic chk_out(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, pc_write, ifid_write, ifid_flush, hazard_ctrl_mux, pipe_en, halted},
        {26'd0, exp});
    $display("%0t %s outs=%b%b%b%b%b%b stall=%0d flush=%0d freeze=%0d", $time, tag,
             pc_write, ifid_write, ifid_flush, hazard_ctrl_mux, pipe_en, halted,
             stall_cnt, flush_cnt, freeze_cnt);
  endtask

  task automatic chk_cnt(input string tag, input int s, input int f, input int z);
    chk({tag, "_stall"}, {28'd0, stall_cnt}, s);
    chk({tag, "_flush"}, {28'd0, flush_cnt}, f);
    chk({tag, "_freeze"}, {28'd0, freeze_cnt}, z);
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; dmem_busy = 1'b0; wb_halt = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
  endtask

  // Output vector order: pc_write ifid_write ifid_flush hazard_ctrl_mux pipe_en halted
  initial begin
    idle();
    rst = 1'b1;
    wb_halt = 1'b1; dmem_busy = 1'b1; ex_branch_taken = 1'b1;
    step();
    step();
    chk_out("rst_outputs", 6'b110010);
    chk_cnt("rst", 0, 0, 0);
    rst = 1'b0;
    idle();
    #1;
    chk_out("normal", 6'b110010);

    set_load_use();
    #1;
    chk_out("load_use", 6'b000110);
    step();
    chk_cnt("load_use", 1, 0, 0);
    ex_mem_read = 1'b0;
    #1;
    chk_out("after_load_use", 6'b110010);
    step();
    chk_cnt("after_load_use", 1, 0, 0);

    set_load_use();
    ex_rd = 5'd0; id_rs1 = 5'd0;
    #1;
    chk_out("x0_no_stall", 6'b110010);
    step();
    chk_cnt("x0_no_stall", 1, 0, 0);

    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd3; id_rs1_used = 1'b1;
    id_rs2 = 5'd5; id_rs2_used = 1'b0;
    #1;
    chk_out("rs2_unused", 6'b110010);
    step();
    chk_cnt("rs2_unused", 1, 0, 0);
    id_rs2_used = 1'b1;
    #1;
    chk_out("rs2_used", 6'b000110);
    step();
    chk_cnt("rs2_used", 2, 0, 0);

    idle();
    set_load_use();
    ex_branch_taken = 1'b1;
    #1;
    chk_out("branch_load_use", 6'b111110);
    step();
    chk_cnt("branch_load_use", 2, 1, 0);
    idle();

    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_cnt("rst_pulse", 0, 0, 0);

    dmem_busy = 1'b1; ex_branch_taken = 1'b1;
    #1;
    chk_out("freeze_c1", 6'b000000);
    step();
    chk_out("freeze_c2", 6'b000000);
    step();
    chk_out("freeze_c3", 6'b000000);
    step();
    chk_cnt("freeze_hold", 0, 0, 3);
    dmem_busy = 1'b0;
    #1;
    chk_out("freeze_exit", 6'b111110);
    step();
    chk_cnt("freeze_exit", 0, 1, 3);
    ex_branch_taken = 1'b0;
    #1;
    chk_out("post_freeze", 6'b110010);

    wb_halt = 1'b1;
    #1;
    chk_out("halt_req", 6'b000000);
    step();
    wb_halt = 1'b0;
    #1;
    chk_out("halted", 6'b000001);
    set_load_use();
    ex_branch_taken = 1'b1; dmem_busy = 1'b1; wb_halt = 1'b1;
    #1;
    chk_out("halted_hazards", 6'b000001);
    step();
    step();
    chk_out("halted_stays", 6'b000001);
    chk_cnt("halted", 0, 1, 3);
    idle();
    rst = 1'b1;
    #1;
    chk_out("halt_rst_outputs", 6'b110010);
    step();
    rst = 1'b0;
    #1;
    chk_out("halt_released", 6'b110010);
    chk_cnt("halt_released", 0, 0, 0);

    set_load_use();
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("sat_cycle%0d", i), {28'd0, stall_cnt}, (i + 1 > 15) ? 15 : i + 1);
    end
    chk_cnt("saturated", 15, 0, 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
